ts_pkt_sync: RTL
================

Name: ts_pkt_sync

Overview:
- Packet synchroniser for the 8-bit parallel TS interface; sits directly upstream of a TS parallel sink.
- Consumes a raw byte stream (data + valid, no sync) and hunts for the sync byte at the packet spacing.
- Locks after a run of good sync bytes and then emits a TS parallel stream: data/sync/valid with sync on byte 0 of each packet.
- Provides flywheel tolerance of missed sync bytes, plus lock and sync-loss status.

Parameters:
PKT_LEN, 188, packet length in bytes (valid range 2..255)
SYNC_BYTE, 8'h47, sync byte value
LOCK_CNT, 3, consecutive correctly spaced sync bytes required to lock, including the first (valid range 1..15)
UNLOCK_CNT, 3, consecutive missed sync bytes that drop lock (valid range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
ts_par_data_i  input  8  raw byte
ts_par_valid_i  input  1  byte qualifier
ts_par_data_o  output  8  aligned byte
ts_par_sync_o  output  1  high with byte 0 of a packet
ts_par_valid_o  output  1  output byte qualifier
ts_par_err_o  output  1  high with ts_par_sync_o when byte 0 != SYNC_BYTE (tolerated miss)
lock_o  output  1  high while in LOCKED
sync_loss_cnt_o  output  8  count of lock losses, saturates at 255

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state HUNT, all counters 0.
- Input handling:
  - Only cycles with ts_par_valid_i=1 advance any state or counter.
  - valid_i=0 holds all state; ts_par_valid_o is 0 on the following cycle.
- Latency: outputs are registered, 1 cycle after the input byte. ts_par_data_o is the registered input byte whenever valid_o=1.
- pos counter (0..PKT_LEN-1) counts valid bytes since the last expected sync position. Wrap: at PKT_LEN-1, the next valid byte gets pos 0.
- HUNT:
  - valid byte == SYNC_BYTE: set good=1, pos=0.
  - If LOCK_CNT==1, go to LOCKED; otherwise go to VERIFY.
  - No output in HUNT.
- VERIFY:
  - No output.
  - At each pos 0 byte: if it equals SYNC_BYTE, good+1; when good reaches LOCK_CNT, go to LOCKED on that byte. Otherwise return to HUNT and clear good.
  - Non-zero pos bytes are ignored, even if they equal SYNC_BYTE.
- LOCKED:
  - Every valid byte is output, including the byte that caused the lock.
  - sync_o=1 when pos==0 (flywheel), regardless of the byte value.
  - At pos 0 with byte == SYNC_BYTE: miss=0, err_o=0.
  - At pos 0 with byte != SYNC_BYTE: miss+1.
    - If miss < UNLOCK_CNT: byte is output with sync_o=1 and err_o=1.
    - If miss reaches UNLOCK_CNT: byte is NOT output (valid_o=0), go to HUNT, clear miss, sync_loss_cnt+1 (saturating).
  - The mismatching byte is not re-hunted; by definition it is not SYNC_BYTE.
- lock_o: high from the cycle the locking byte is output through the last output byte before loss.
- Reset mid-operation: takes effect on the next edge. Any partially emitted packet is truncated; downstream detects this by lock_o falling.
- sync_loss_cnt_o is cleared only by rst.

Decomposition:
- Shared package/header (alongside the TS interface header): TS_SYNC_BYTE=8'h47, TS_PKT_LEN=188, TS_PKT_LEN_204=204, and state encodings HUNT/VERIFY/LOCKED.
- No sub-module needed: a single FSM with pos, good and miss counters.

Test Plan:
- Lock: payload bytes 8'h00; SYNC_BYTE at input index 5+188k; valid_i=1 continuously.
  -> lock_o rises and sync_o=1 with data_o=8'h47 one cycle after input index 381.
  -> Thereafter sync_o is high after indices 569, 757, ...
- False sync: as in the lock scenario, plus 8'h47 at index 2.
  -> VERIFY from index 2, returns to HUNT at index 190.
  -> Re-hunts at 193, locks after index 569.
  -> sync_loss_cnt_o stays 0.
- Flywheel: locked, then one packet's sync byte replaced by 8'h00.
  -> sync_o=1 and err_o=1 with data_o=8'h00; lock_o stays 1.
  -> The next good sync clears miss.
- Loss: locked, then three consecutive sync bytes corrupted.
  -> The first two are output with err_o=1; the third is not output.
  -> lock_o falls; sync_loss_cnt_o=1.
  -> Relock after 3 good syncs.
- Gaps: locked stream with valid_i toggled 1/0 every cycle.
  -> pos advances only on valid bytes; sync_o is still on every 8'h47.
  -> valid_o=0 after every idle input cycle.
- Reset: rst=1 for 1 cycle mid-packet while locked.
  -> Next cycle: all outputs 0, lock_o=0, sync_loss_cnt_o=0.
  -> The hunt restarts from the next valid byte.

Source files
------------

// File: rtl/ts_pkt_sync_pkg.sv
// Shared constants, state encoding and output beat type for the TS parallel packet synchroniser.
package ts_pkt_sync_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned TS_PKT_LEN     = 188;
  localparam int unsigned TS_PKT_LEN_204 = 204;
  localparam logic [BYTE_W-1:0] TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  // One beat of the aligned TS parallel output stream.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              sync;
    logic              valid;
    logic              err;
  } ts_beat_t;

endpackage

// File: rtl/ts_pkt_sync.sv
// Hunts for the TS sync byte at packet spacing in a raw byte stream, locks after LOCK_CNT
// good syncs and emits an aligned data/sync/valid stream with flywheel miss tolerance.
module ts_pkt_sync
  import ts_pkt_sync_pkg::*;
#(
  parameter int unsigned        PKT_LEN    = TS_PKT_LEN,
  parameter logic [BYTE_W-1:0]  SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int unsigned        LOCK_CNT   = 3,
  parameter int unsigned        UNLOCK_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] ts_par_data_i,
  input  logic              ts_par_valid_i,
  output logic [BYTE_W-1:0] ts_par_data_o,
  output logic              ts_par_sync_o,
  output logic              ts_par_valid_o,
  output logic              ts_par_err_o,
  output logic              lock_o,
  output logic [BYTE_W-1:0] sync_loss_cnt_o
);

  sync_state_e       state_q, state_d;
  logic [BYTE_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic [BYTE_W-1:0] loss_q, loss_d;
  ts_beat_t          beat_q, beat_d;
  logic              lock_q, lock_d;

  logic [BYTE_W-1:0] pos_adv;
  logic              is_sync;

  // Position the current byte would take, with wrap after the last byte of a packet.
  assign pos_adv = (pos_q == BYTE_W'(PKT_LEN - 1)) ? '0 : pos_q + BYTE_W'(1);
  assign is_sync = (ts_par_data_i == SYNC_BYTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      pos_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      loss_q  <= '0;
      beat_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      loss_q  <= loss_d;
      beat_q  <= beat_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    miss_d      = miss_q;
    loss_d      = loss_q;
    beat_d      = '0;
    beat_d.data = ts_par_data_i;

    if (ts_par_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (is_sync) begin
            pos_d  = '0;
            good_d = CNT_W'(1);
            miss_d = '0;
            if (LOCK_CNT == 1) begin
              state_d      = LOCKED;
              beat_d.valid = 1'b1;
              beat_d.sync  = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end
        end

        VERIFY: begin
          pos_d = pos_adv;
          // Only the expected sync position is examined; sync-valued payload is ignored.
          if (pos_adv == '0) begin
            if (is_sync) begin
              good_d = good_q + CNT_W'(1);
              if (good_q + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
                state_d      = LOCKED;
                beat_d.valid = 1'b1;
                beat_d.sync  = 1'b1;
              end
            end else begin
              state_d = HUNT;
              good_d  = '0;
            end
          end
        end

        LOCKED: begin
          pos_d = pos_adv;
          if (pos_adv != '0) begin
            beat_d.valid = 1'b1;
          end else if (is_sync) begin
            miss_d       = '0;
            beat_d.valid = 1'b1;
            beat_d.sync  = 1'b1;
          end else if (miss_q + CNT_W'(1) < CNT_W'(UNLOCK_CNT)) begin
            miss_d       = miss_q + CNT_W'(1);
            beat_d.valid = 1'b1;
            beat_d.sync  = 1'b1;
            beat_d.err   = 1'b1;
          end else begin
            // Too many misses: drop this byte and lock, hunt again from the next byte.
            state_d = HUNT;
            miss_d  = '0;
            good_d  = '0;
            if (loss_q != '1) begin
              loss_d = loss_q + BYTE_W'(1);
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    lock_d = (state_d == LOCKED);
  end

  assign ts_par_data_o   = beat_q.data;
  assign ts_par_sync_o   = beat_q.sync;
  assign ts_par_valid_o  = beat_q.valid;
  assign ts_par_err_o    = beat_q.err;
  assign lock_o          = lock_q;
  assign sync_loss_cnt_o = loss_q;

endmodule
